slave_tx485: RTL and testbench

- Slave-end RS-485 uplink transmitter: the counterpart of the master, which drives ctrl/syn lines and receives two data lanes (a, b).
- On each master sync rising edge, while ctrl enables the link, it latches two data words and serializes them simultaneously on lanes tx_a and tx_b.
- It drives the 485 driver-enable around each frame.
- Runs on clk_sys, timed by the 1 us pluse_us tick from the clock/reset block.

---
 rtl/slave_tx485.sv | 251 +++++++++++++++++++++++++
 tb/tb_slave_tx485.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_tx485.sv
// Slave-end RS-485 uplink transmitter.
// On each synchronized rising edge of the master sync line, while the master
// control line enables the link, two data words are captured and shifted out
// LSB first on lanes a and b in lockstep. Each lane sends a start bit, DW data
// bits, an even-parity bit and a stop bit. The 485 driver enable is raised
// after a turnaround delay and held through a guard interval after the stop
// bit. All bit timing is counted in 1 us ticks (pluse_us).
module slave_tx485 #(
  parameter int DW       = 16,
  parameter int BIT_US   = 4,
  parameter int DLY_US   = 8,
  parameter int GUARD_US = 2
) (
  input  logic          i_clk_sys,
  input  logic          i_rst_n,
  input  logic          i_pluse_us,
  input  logic          i_rx_syn,
  input  logic          i_rx_ctrl,
  input  logic [DW-1:0] i_data_a,
  input  logic [DW-1:0] i_data_b,
  output logic          o_data_ack,
  output logic          o_tx_a,
  output logic          o_tx_b,
  output logic          o_tx_en,
  output logic          o_busy,
  output logic          o_ovr,
  output logic [15:0]   o_frm_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_GUARD
  } state_t;

  // Tick values on which each timed phase ends (a delay of 0 never compares)
  localparam logic [7:0] L_BIT_LAST   = 8'(BIT_US - 1);
  localparam logic [7:0] L_DLY_LAST   = 8'(DLY_US - 1);
  localparam logic [7:0] L_GUARD_LAST = 8'(GUARD_US - 1);
  localparam logic [4:0] L_IDX_LAST   = 5'(DW - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_syn_s1;
  logic          r_syn_s2;
  logic          r_syn_d3;
  logic          r_ctrl_s1;
  logic          r_ctrl_s2;
  logic          w_syn_edge;

  logic [7:0]    r_tick;
  logic [7:0]    w_tick_next;
  logic          w_tick_clr;
  logic          w_bit_done;
  logic          w_dly_done;
  logic          w_guard_done;

  logic [4:0]    r_bit_idx;
  logic [DW-1:0] r_sh_a;
  logic [DW-1:0] r_sh_b;
  logic [DW-1:0] w_sh_a_nx;
  logic [DW-1:0] w_sh_b_nx;
  logic          r_par_a;
  logic          r_par_b;

  logic          r_tx_a;
  logic          r_tx_b;
  logic          r_tx_en;
  logic          r_data_ack;
  logic          r_ovr;
  logic [15:0]   r_frm_cnt;

  logic          w_tx_a_next;
  logic          w_tx_b_next;
  logic          w_tx_en_next;
  logic          w_latch;
  logic          w_shift;
  logic          w_ovr;
  logic          w_frm_inc;

  // Two-flop synchronizers for the asynchronous master lines, plus an edge flop on sync
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_syn_s1  <= 1'b0;
      r_syn_s2  <= 1'b0;
      r_syn_d3  <= 1'b0;
      r_ctrl_s1 <= 1'b0;
      r_ctrl_s2 <= 1'b0;
    end else begin
      r_syn_s1  <= i_rx_syn;
      r_syn_s2  <= r_syn_s1;
      r_syn_d3  <= r_syn_s2;
      r_ctrl_s1 <= i_rx_ctrl;
      r_ctrl_s2 <= r_ctrl_s1;
    end
  end

  assign w_syn_edge   = r_syn_s2 & ~r_syn_d3;
  assign w_bit_done   = i_pluse_us && (r_tick == L_BIT_LAST);
  assign w_dly_done   = (DLY_US == 0) || (i_pluse_us && (r_tick == L_DLY_LAST));
  assign w_guard_done = (GUARD_US == 0) || (i_pluse_us && (r_tick == L_GUARD_LAST));
  assign w_sh_a_nx    = r_sh_a >> 1;
  assign w_sh_b_nx    = r_sh_b >> 1;

  // Tick counter restarts on every state change and on each data bit boundary
  assign w_tick_next = ((w_state_next != r_state) || w_tick_clr) ? 8'd0 :
                       (i_pluse_us ? r_tick + 8'd1 : r_tick);

  // Next-state logic and the next values of the registered line outputs
  always_comb begin
    w_state_next = r_state;
    w_tx_a_next  = r_tx_a;
    w_tx_b_next  = r_tx_b;
    w_tx_en_next = r_tx_en;
    w_latch      = 1'b0;
    w_shift      = 1'b0;
    w_tick_clr   = 1'b0;
    w_frm_inc    = 1'b0;
    w_ovr        = w_syn_edge && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_syn_edge && r_ctrl_s2) begin
          w_state_next = S_WAIT;
          w_latch      = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_dly_done) begin
          w_state_next = S_START;
          w_tx_a_next  = 1'b0;
          w_tx_b_next  = 1'b0;
          w_tx_en_next = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_next = S_DATA;
          w_tx_a_next  = r_sh_a[0];
          w_tx_b_next  = r_sh_b[0];
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == L_IDX_LAST) begin
            w_state_next = S_PAR;
            w_tx_a_next  = r_par_a;
            w_tx_b_next  = r_par_b;
          end else begin
            w_shift     = 1'b1;
            w_tick_clr  = 1'b1;
            w_tx_a_next = w_sh_a_nx[0];
            w_tx_b_next = w_sh_b_nx[0];
          end
        end
      end
      S_PAR: begin
        if (w_bit_done) begin
          w_state_next = S_STOP;
          w_tx_a_next  = 1'b1;
          w_tx_b_next  = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          if (GUARD_US == 0) begin
            w_state_next = S_IDLE;
            w_tx_en_next = 1'b0;
            w_frm_inc    = 1'b1;
          end else begin
            w_state_next = S_GUARD;
          end
        end
      end
      S_GUARD: begin
        if (w_guard_done) begin
          w_state_next = S_IDLE;
          w_tx_en_next = 1'b0;
          w_frm_inc    = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_a_next  = 1'b1;
        w_tx_b_next  = 1'b1;
        w_tx_en_next = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: tick counter, shift registers, line outputs, pulses and frame counter
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick     <= 8'd0;
      r_bit_idx  <= 5'd0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_par_a    <= 1'b0;
      r_par_b    <= 1'b0;
      r_tx_a     <= 1'b1;
      r_tx_b     <= 1'b1;
      r_tx_en    <= 1'b0;
      r_data_ack <= 1'b0;
      r_ovr      <= 1'b0;
      r_frm_cnt  <= 16'd0;
    end else begin
      r_tick     <= w_tick_next;
      r_tx_a     <= w_tx_a_next;
      r_tx_b     <= w_tx_b_next;
      r_tx_en    <= w_tx_en_next;
      r_data_ack <= w_latch;
      r_ovr      <= w_ovr;
      if (w_latch) begin
        r_sh_a    <= i_data_a;
        r_sh_b    <= i_data_b;
        r_par_a   <= ^i_data_a;
        r_par_b   <= ^i_data_b;
        r_bit_idx <= 5'd0;
      end else if (w_shift) begin
        r_sh_a    <= w_sh_a_nx;
        r_sh_b    <= w_sh_b_nx;
        r_bit_idx <= r_bit_idx + 5'd1;
      end
      if (w_frm_inc) begin
        r_frm_cnt <= r_frm_cnt + 16'd1;
      end
    end
  end

  assign o_tx_a     = r_tx_a;
  assign o_tx_b     = r_tx_b;
  assign o_tx_en    = r_tx_en;
  assign o_data_ack = r_data_ack;
  assign o_ovr      = r_ovr;
  assign o_frm_cnt  = r_frm_cnt;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_slave_tx485.sv
// Testbench for slave_tx485: one instance with default timing and a 1 us tick
// every 10 clocks, one instance with zero delay/guard and a tick every clock.
// Expected lane frames are queued when a sync is issued and compared when the
// transmitter produces them.
module tb_slave_tx485;

  localparam int DW       = 16;
  localparam int BIT_US   = 4;
  localparam int DLY_US   = 8;
  localparam int GUARD_US = 2;
  localparam int US_CYC   = 10;
  localparam int BIT_CYC  = BIT_US * US_CYC;
  localparam int NBITS    = DW + 3;

  typedef struct packed {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
  } frameT;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          pulseUs = 1'b0;
  logic          rxSyn = 1'b0;
  logic          rxCtrl = 1'b0;
  logic [DW-1:0] dataA = '0;
  logic [DW-1:0] dataB = '0;
  logic          dataAck, txA, txB, txEn, busy, ovr;
  logic [15:0]   frmCnt;

  logic          rxSyn0 = 1'b0;
  logic [DW-1:0] dataA0 = '0;
  logic [DW-1:0] dataB0 = '0;
  logic          dataAck0, txA0, txB0, txEn0, busy0, ovr0;
  logic [15:0]   frmCnt0;

  int    compared = 0;
  int    mismatched = 0;
  frameT frameQ[$];
  frameT fastQ[$];
  bit    allowUnexpected = 1'b0;
  int    lat, cnt, ovrCnt, ackCnt, enCnt, busyCnt;

  slave_tx485 #(.DW(DW), .BIT_US(BIT_US), .DLY_US(DLY_US), .GUARD_US(GUARD_US)) dut (
    .i_clk_sys (clk),
    .i_rst_n   (rstN),
    .i_pluse_us(pulseUs),
    .i_rx_syn  (rxSyn),
    .i_rx_ctrl (rxCtrl),
    .i_data_a  (dataA),
    .i_data_b  (dataB),
    .o_data_ack(dataAck),
    .o_tx_a    (txA),
    .o_tx_b    (txB),
    .o_tx_en   (txEn),
    .o_busy    (busy),
    .o_ovr     (ovr),
    .o_frm_cnt (frmCnt)
  );

  slave_tx485 #(.DW(DW), .BIT_US(BIT_US), .DLY_US(0), .GUARD_US(0)) dut0 (
    .i_clk_sys (clk),
    .i_rst_n   (rstN),
    .i_pluse_us(1'b1),
    .i_rx_syn  (rxSyn0),
    .i_rx_ctrl (rxCtrl),
    .i_data_a  (dataA0),
    .i_data_b  (dataB0),
    .o_data_ack(dataAck0),
    .o_tx_a    (txA0),
    .o_tx_b    (txB0),
    .o_tx_en   (txEn0),
    .o_busy    (busy0),
    .o_ovr     (ovr0),
    .o_frm_cnt (frmCnt0)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // One-cycle 1 us tick every US_CYC clocks, changed away from the active edge
  initial begin
    forever begin
      repeat (US_CYC - 1) @(negedge clk);
      pulseUs = 1'b1;
      @(negedge clk);
      pulseUs = 1'b0;
    end
  end

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NBITS-1:0] makeFrame(input logic [DW-1:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise sync with the given words and wait (bounded) for the data acknowledge
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input bit expectFrame, output int ackLat);
    frameT f;
    @(negedge clk);
    dataA = a;
    dataB = b;
    rxSyn = 1'b1;
    if (expectFrame) begin
      f.a = makeFrame(a);
      f.b = makeFrame(b);
      frameQ.push_back(f);
    end
    ackLat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (dataAck) begin
        ackLat = i;
        break;
      end
    end
    rxSyn = 1'b0;
    dataA = 16'($urandom);
    dataB = 16'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  task automatic waitTxEn();
    int n;
    n = 0;
    while (!txEn && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txEnTimeout", 32'(txEn), 32'd1);
  endtask

  // Frame on the zero-delay instance: checks start latency, enable length and lane bits
  task automatic runFast(input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
    frameT f;
    frameT e;
    logic [NBITS-1:0] gotA, gotB;
    int n;
    f.a = makeFrame(a);
    f.b = makeFrame(b);
    fastQ.push_back(f);
    @(negedge clk);
    dataA0 = a;
    dataB0 = b;
    rxSyn0 = 1'b1;
    n = 0;
    while (!dataAck0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    rxSyn0 = 1'b0;
    dataA0 = 16'($urandom);
    dataB0 = 16'($urandom);
    checkOutput({tag, "AckLat"}, 32'(n), 32'd3);
    @(negedge clk);
    checkOutput({tag, "StartNextCycle"}, 32'(txEn0), 32'd1);
    gotA = '1;
    gotB = '1;
    n = 0;
    while (txEn0 && n < 200) begin
      if ((n % BIT_US) == 1 && (n / BIT_US) < NBITS) begin
        gotA[n / BIT_US] = txA0;
        gotB[n / BIT_US] = txB0;
      end
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "EnLen"}, 32'(n), 32'(NBITS * BIT_US));
    checkOutput({tag, "BusyDrop"}, 32'(busy0), 32'd0);
    e = fastQ.pop_front();
    checkOutput({tag, "LaneA"}, 32'(gotA), 32'(e.a));
    checkOutput({tag, "LaneB"}, 32'(gotB), 32'(e.b));
  endtask

  // Lane monitor for the default instance: samples each bit mid-period
  initial begin : monitor
    logic prevEn;
    logic [NBITS-1:0] gotA, gotB;
    frameT e;
    prevEn = 1'b0;
    forever begin
      @(negedge clk);
      if (txEn && !prevEn) begin
        if (frameQ.size() == 0) begin
          if (!allowUnexpected) checkOutput("unexpectedFrame", 32'd1, 32'd0);
        end else begin
          e = frameQ.pop_front();
          repeat (BIT_CYC / 2) @(negedge clk);
          for (int k = 0; k < NBITS; k++) begin
            gotA[k] = txA;
            gotB[k] = txB;
            if (k < NBITS - 1) repeat (BIT_CYC) @(negedge clk);
          end
          checkOutput("laneA", 32'(gotA), 32'(e.a));
          checkOutput("laneB", 32'(gotB), 32'(e.b));
        end
      end
      prevEn = txEn;
    end
  end

  // Main sequence
  initial begin
    rstN = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rstTxA", 32'(txA), 32'd1);
    checkOutput("rstTxB", 32'(txB), 32'd1);
    checkOutput("rstTxEn", 32'(txEn), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAck", 32'(dataAck), 32'd0);
    checkOutput("rstOvr", 32'(ovr), 32'd0);
    checkOutput("rstFrm", 32'(frmCnt), 32'd0);
    rstN = 1'b1;
    rxCtrl = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] basic frame");
    applyStimulus(16'hA5C3, 16'h0001, 1'b1, lat);
    checkOutput("ackLatency", 32'(lat), 32'd3);
    cnt = 0;
    while (!txEn && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("enDelayInRange",
                32'((cnt >= (DLY_US - 1) * US_CYC + 1) && (cnt <= DLY_US * US_CYC)), 32'd1);
    waitIdle();
    checkOutput("frmCnt1", 32'(frmCnt), 32'd1);
    checkOutput("queueDrained1", 32'(frameQ.size()), 32'd0);

    $display("[TB] ctrl low gates new frames");
    rxCtrl = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(16'h1111, 16'h2222, 1'b0, lat);
    checkOutput("noAckCtrlLow", 32'(lat), 32'd0);
    enCnt = 0;
    busyCnt = 0;
    ovrCnt = 0;
    repeat (40) begin
      @(negedge clk);
      enCnt += int'(txEn);
      busyCnt += int'(busy);
      ovrCnt += int'(ovr);
    end
    checkOutput("ctrlLowTxEn", 32'(enCnt), 32'd0);
    checkOutput("ctrlLowBusy", 32'(busyCnt), 32'd0);
    checkOutput("ctrlLowOvr", 32'(ovrCnt), 32'd0);
    rxCtrl = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] sync while busy");
    applyStimulus(16'h3C96, 16'hF00F, 1'b1, lat);
    waitTxEn();
    repeat (BIT_CYC * 5) @(negedge clk);
    ovrCnt = 0;
    ackCnt = 0;
    rxSyn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 4) rxSyn = 1'b0;
      ovrCnt += int'(ovr);
      ackCnt += int'(dataAck);
    end
    checkOutput("ovrPulses", 32'(ovrCnt), 32'd1);
    checkOutput("noReAck", 32'(ackCnt), 32'd0);
    waitIdle();
    checkOutput("frmCnt2", 32'(frmCnt), 32'd2);

    $display("[TB] reset mid-frame");
    allowUnexpected = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 1'b0, lat);
    waitTxEn();
    repeat (BIT_CYC * 8 + BIT_CYC / 2) @(negedge clk);
    checkOutput("preRstTxA", 32'(txA), 32'd0);
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstTxA", 32'(txA), 32'd1);
    checkOutput("asyncRstTxB", 32'(txB), 32'd1);
    checkOutput("asyncRstTxEn", 32'(txEn), 32'd0);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstFrm", 32'(frmCnt), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    allowUnexpected = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(16'h1234, 16'hBEEF, 1'b1, lat);
    checkOutput("ackLatencyAfterRst", 32'(lat), 32'd3);
    waitIdle();
    checkOutput("frmCntAfterRst", 32'(frmCnt), 32'd1);
    checkOutput("queueDrained2", 32'(frameQ.size()), 32'd0);

    $display("[TB] zero delay and guard, tick every cycle");
    repeat (3) @(negedge clk);
    runFast(16'h5A0F, 16'h8001, "fast1");
    checkOutput("fastFrm1", 32'(frmCnt0), 32'd1);
    repeat (3) @(negedge clk);
    force dut0.r_frm_cnt = 16'hFFFF;
    #1;
    release dut0.r_frm_cnt;
    @(negedge clk);
    checkOutput("preloadCnt", 32'(frmCnt0), 32'h0000FFFF);
    runFast(16'hFFFF, 16'h7FFE, "fast2");
    checkOutput("frmCntWrap", 32'(frmCnt0), 32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
